dmem_access_unit: RTL
=====================

# dmem_access_unit

Load/store responder for the data-memory side of the RV32I core. It consumes the decoder's data-memory read/write enables and funct3 size code. It runs one request/response transaction on a simple single-port memory bus, stalling the pipeline until the access completes. It generates byte-lane masks and replicated write data for stores, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses without touching the bus.

## Interface
- TIMEOUT, 255, bus-wait cycle limit (used only with DMEM_TIMEOUT_EN)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_rd_en  in  1  load request (decoder dmem read enable)
- i_wr_en  in  1  store request (decoder dmem write enable)
- i_funct3  in  3  access size/sign code
- i_addr  in  32  byte address from ALU
- i_wdata  in  32  store data (rs2)
- o_rdata  out  32  extended load result
- o_busy  out  1  pipeline stall
- o_done  out  1  one-cycle completion pulse
- o_fault  out  1  one-cycle pulse: misaligned, illegal funct3, both enables, or timeout
- o_bus_valid  out  1  bus request valid
- o_bus_we  out  1  1 = write
- o_bus_addr  out  32  word address, {i_addr[31:2],2'b00}
- o_bus_wdata  out  32  lane-replicated write data
- o_bus_mask  out  4  byte-lane write strobes; 4'b0000 on reads
- i_bus_ready  in  1  slave accepts request
- i_bus_rvalid  in  1  read data valid
- i_bus_rdata  in  32  read data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE, no enable: stays in IDLE.
- IDLE, an enable is set: latches addr, funct3, wdata and direction, then decides the next state.
  - Goes to FAULT if the request is illegal.
  - Goes to REQ otherwise.
- Illegal requests:
  - both enables set;
  - load funct3 not in {000,001,010,100,101};
  - store funct3 not in {000,001,010};
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- REQ: o_bus_valid=1, holding all bus outputs stable until i_bus_ready.
  - On ready with a store: goes to DONE.
  - On ready with a load: goes to WAIT.
- WAIT: on i_bus_rvalid, captures the extended result into o_rdata and goes to DONE. i_bus_rvalid is ignored outside WAIT.
- DONE: o_done=1, goes to IDLE.
- FAULT: o_fault=1, goes to IDLE. No bus activity and o_rdata is unchanged.
- Store lanes, with o = addr[1:0]:
  - byte: wdata={4{wdata[7:0]}}, mask=4'b0001<<o;
  - half: wdata={2{wdata[15:0]}}, mask=4'b0011<<o;
  - word: wdata unchanged, mask=4'b1111.
- Load extract: selects the byte/half by addr[1:0] from i_bus_rdata.
  - 000/001: sign-extend.
  - 100/101: zero-extend.
  - 010: whole word.
- o_rdata holds its value until the next completed load.

## Timing
- Reset values: state IDLE, o_rdata=0, and every other output 0.
- Asynchronous reset mid-transaction drops o_bus_valid immediately and returns to IDLE. The slave must tolerate the abandoned request.
- o_busy is combinational and high in:
  - the IDLE cycle an enable is seen;
  - all REQ and WAIT cycles.
- o_busy is low in DONE and FAULT, so the core advances there and the next request can be sampled the cycle after DONE/FAULT.
- The core holds i_* stable while o_busy=1. The unit uses only the values latched in the IDLE cycle.
- Zero-wait store: cycle0 IDLE (busy), cycle1 REQ accepted, cycle2 DONE. Latency is 2 cycles.
- Zero-wait load (ready in the REQ cycle, rvalid the next cycle): cycle0 IDLE, cycle1 REQ, cycle2 WAIT, cycle3 DONE with o_rdata valid. Latency is 3 cycles.
- Each cycle i_bus_ready is held low in REQ, or i_bus_rvalid is held low in WAIT, adds exactly one cycle.
- Illegal request: the FAULT pulse is in cycle1.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - an 8-bit-or-wider counter clears on entry to REQ and counts in REQ and WAIT;
  - when it reaches TIMEOUT, the unit deasserts o_bus_valid, goes to FAULT and pulses o_fault;
  - late i_bus_ready/i_bus_rvalid after the abort are ignored.
- DMEM_TIMEOUT_EN undefined: no counter is built and the unit waits indefinitely in REQ/WAIT.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ready immediate -> bus_addr=0x100, mask=4'b1111, bus_wdata=0xDEADBEEF; o_done in cycle2; busy high only in cycles 0-1.
- SB addr=0x103, wdata=0x000000A5 -> mask=4'b1000, bus_wdata=0xA5A5A5A5.
- LB addr=0x202 with rdata=0x12F34567 -> o_rdata=0xFFFFFFF3; LBU on the same word -> 0x000000F3; LHU addr=0x202 -> 0x000012F3.
- LW addr=0x301 -> o_fault pulse in cycle1, o_bus_valid never asserted, o_rdata unchanged; funct3=011 load -> o_fault.
- Load with ready delayed 3 cycles and rvalid delayed 2 cycles -> o_done in cycle8; bus outputs stable throughout REQ.
- i_rst asserted while in WAIT -> o_bus_valid=0 and o_busy=0 immediately; a subsequent SW completes normally. With DMEM_TIMEOUT_EN and TIMEOUT=4 and ready never given -> o_fault after 4 REQ cycles.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: RV32I data-memory load/store responder with byte-lane steering and fault detection.
// Optional bus-wait abort is built only when DMEM_TIMEOUT_EN is defined.
module dmem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rd_en,
   input  logic        i_wr_en,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_fault,
   output logic        o_bus_valid,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_mask,
   input  logic        i_bus_ready,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;

   state_t      state, state_next;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        req_we;
   logic        req;
   logic        timed_out;

   function automatic logic is_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      ok = !(rd && wr);
      case (f3)
         3'b000:  ;
         3'b001:  if (off[0]) ok = 1'b0;
         3'b010:  if (off != 2'b00) ok = 1'b0;
         3'b100:  if (wr) ok = 1'b0;
         3'b101:  if (wr || off[0]) ok = 1'b0;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] lane_data(input logic [31:0] w, input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return {4{w[7:0]}};
         2'b01:   return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return 4'b0001 << off;
         2'b01:   return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Shifting the word down by the byte offset puts the addressed byte/half at bit 0.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   // Holding reset keeps the stall low even if the core still presents an enable.
   assign req = (i_rd_en | i_wr_en) & ~i_rst;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         wait_cnt <= '0;
      else if (state == REQ || state == WAIT)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_fault     = 1'b0;
      o_bus_valid = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               o_busy     = 1'b1;
               state_next = is_legal(i_rd_en, i_wr_en, i_funct3, i_addr[1:0]) ? REQ : FAULT;
            end
         end
         REQ: begin
            o_busy      = 1'b1;
            o_bus_valid = 1'b1;
            if (i_bus_ready)
               state_next = req_we ? DONE : WAIT;
            else if (timed_out)
               state_next = FAULT;
         end
         WAIT: begin
            o_busy = 1'b1;
            if (i_bus_rvalid)
               state_next = DONE;
            else if (timed_out)
               state_next = FAULT;
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         FAULT: begin
            o_fault    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         req_addr   <= '0;
         req_funct3 <= '0;
         req_wdata  <= '0;
         req_we     <= 1'b0;
         o_rdata    <= '0;
      end else begin
         if (state == IDLE && req) begin
            req_addr   <= i_addr;
            req_funct3 <= i_funct3;
            req_wdata  <= i_wdata;
            req_we     <= i_wr_en;
         end
         if (state == WAIT && i_bus_rvalid)
            o_rdata <= load_extend(i_bus_rdata, req_funct3, req_addr[1:0]);
      end
   end

   assign o_bus_we    = req_we & (state == REQ);
   assign o_bus_addr  = {req_addr[31:2], 2'b00};
   assign o_bus_wdata = lane_data(req_wdata, req_funct3);
   assign o_bus_mask  = (req_we && state == REQ) ? lane_mask(req_funct3, req_addr[1:0]) : 4'b0000;

endmodule
